// File: rtl/uart_wb_pkg.sv
// Shared constants for the UART-to-Wishbone debug bridge: opcodes, status
// codes, bus tag width and the command parser state encoding.
package uart_wb_pkg;

  localparam logic [7:0] OP_WRITE   = 8'h57;
  localparam logic [7:0] OP_READ    = 8'h52;

  localparam logic [7:0] ST_ACK     = 8'h00;
  localparam logic [7:0] ST_ERR     = 8'h01;
  localparam logic [7:0] ST_TIMEOUT = 8'h02;

  localparam int TAG_WIDTH = 4;

  typedef enum logic [2:0] {
    P_IDLE,
    P_ADDR,
    P_WDATA,
    P_BUS,
    P_RESP
  } pstate_e;

  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OP_WRITE) || (b == OP_READ);
  endfunction

endpackage

// File: rtl/uart_wb_bridge_if.sv
// Single-master Wishbone bundle driven by the UART bridge.
interface uart_wb_bridge_if #(
  parameter int ADDR_WIDTH = 32
);
  import uart_wb_pkg::*;

  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [TAG_WIDTH-1:0]  tag;
  logic [3:0]            sel;
  logic [ADDR_WIDTH-1:0] adr;
  logic [31:0]           mosi;
  logic [31:0]           miso;
  logic                  ack;
  logic                  err;

  modport master (output cyc, stb, we, tag, sel, adr, mosi, input miso, ack, err);
  modport slave  (input cyc, stb, we, tag, sel, adr, mosi, output miso, ack, err);

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle
// byte_valid_o pulse per byte whose stop bit samples high.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 260
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o
);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] MID  = 16'(CLKS_PER_BIT / 2);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rstate_e;

  rstate_e     st_q;
  logic        s1_q, s2_q, prev_q, vld_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  sh_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
      st_q   <= R_IDLE;
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      vld_q  <= 1'b0;
    end else begin
      s1_q   <= rx_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      vld_q  <= 1'b0;
      cnt_q  <= (st_q == R_IDLE || cnt_q == LAST) ? '0 : cnt_q + 16'd1;
      // Every sample is taken at MID; bit boundaries fall on the counter wrap.
      case (st_q)
        R_IDLE:  if (prev_q && !s2_q) st_q <= R_START;
        R_START: begin
          if (cnt_q == MID && s2_q) st_q <= R_IDLE;
          else if (cnt_q == LAST) begin
            st_q  <= R_DATA;
            bit_q <= '0;
          end
        end
        R_DATA: begin
          if (cnt_q == MID) sh_q <= {s2_q, sh_q[7:1]};
          if (cnt_q == LAST) begin
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) st_q <= R_STOP;
          end
        end
        R_STOP: if (cnt_q == MID) begin
          vld_q <= s2_q;
          st_q  <= R_IDLE;
        end
        default: st_q <= R_IDLE;
      endcase
    end
  end

  assign byte_valid_o = vld_q;
  assign byte_o       = sh_q;

endmodule

// File: rtl/uart_wb_bridge.sv
// UART-driven Wishbone master: parses 'W'/'R' command frames, runs one bus
// cycle, replies over UART. Define UART_WB_BRIDGE_TIMEOUT_EN for bus timeout.
module uart_wb_bridge
  import uart_wb_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 260,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic uart_rx,
  output logic uart_tx,
  output logic busy,
  uart_wb_bridge_if.master wb
);
  localparam logic [15:0] TX_LAST = 16'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 4 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("uart_wb_bridge: CLKS_PER_BIT must be >= 4 and TIMEOUT_CYCLES >= 1");
  end

  logic                  rx_vld;
  logic [7:0]            rx_byte;
  pstate_e               state_q, state_d;
  logic                  we_q;
  logic [1:0]            bcnt_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [31:0]           wdat_q;
  logic [9:0]            tx_sh_q;
  logic [15:0]           tx_cnt_q;
  logic [3:0]            tx_bit_q;
  logic                  tx_act_q;
  logic [31:0]           resp_q;
  logic [2:0]            left_q;
  logic                  tmo_hit, term, tx_done;
  logic [7:0]            status;
  logic [39:0]           resp_full;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_i        (sys_clk),
    .rst_i        (sys_rst),
    .rx_i         (uart_rx),
    .byte_valid_o (rx_vld),
    .byte_o       (rx_byte)
  );

`ifdef UART_WB_BRIDGE_TIMEOUT_EN
  logic [31:0] tmo_q;
  always_ff @(posedge sys_clk) begin
    if (sys_rst || state_q != P_BUS) tmo_q <= '0;
    else                             tmo_q <= tmo_q + 32'd1;
  end
  assign tmo_hit = (state_q == P_BUS) && (tmo_q == 32'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // err beats ack, ack beats a timeout landing in the same cycle
  assign term      = (state_q == P_BUS) && (wb.ack || wb.err || tmo_hit);
  assign status    = wb.err ? ST_ERR : (wb.ack ? ST_ACK : ST_TIMEOUT);
  assign resp_full = we_q ? {status, 32'h0}
                          : {((wb.ack && !wb.err) ? wb.miso : 32'h0), status};
  assign tx_done   = tx_act_q && (tx_cnt_q == TX_LAST) && (tx_bit_q == 4'd9);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= P_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      P_IDLE:  if (rx_vld && is_opcode(rx_byte))  state_d = P_ADDR;
      P_ADDR:  if (rx_vld && bcnt_q == 2'd3)      state_d = we_q ? P_WDATA : P_BUS;
      P_WDATA: if (rx_vld && bcnt_q == 2'd3)      state_d = P_BUS;
      P_BUS:   if (term)                          state_d = P_RESP;
      P_RESP:  if (tx_done && left_q == 3'd0)     state_d = P_IDLE;
      default: state_d = P_IDLE;
    endcase
  end

  always_comb begin
    wb.cyc  = 1'b0;
    wb.stb  = 1'b0;
    wb.we   = 1'b0;
    wb.tag  = '0;
    wb.sel  = 4'h0;
    wb.adr  = '0;
    wb.mosi = '0;
    busy    = (state_q != P_IDLE);
    if (state_q == P_BUS) begin
      wb.cyc  = 1'b1;
      wb.stb  = 1'b1;
      wb.we   = we_q;
      wb.sel  = 4'hF;
      wb.adr  = adr_q;
      wb.mosi = wdat_q;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      we_q     <= 1'b0;
      bcnt_q   <= '0;
      adr_q    <= '0;
      wdat_q   <= '0;
      tx_sh_q  <= '1;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_act_q <= 1'b0;
      resp_q   <= '0;
      left_q   <= '0;
    end else begin
      if (rx_vld) begin
        case (state_q)
          P_IDLE: begin
            we_q   <= (rx_byte == OP_WRITE);
            bcnt_q <= '0;
          end
          P_ADDR: begin
            adr_q  <= ADDR_WIDTH'({adr_q, rx_byte});
            bcnt_q <= bcnt_q + 2'd1;
          end
          P_WDATA: begin
            wdat_q <= {wdat_q[23:0], rx_byte};
            bcnt_q <= bcnt_q + 2'd1;
          end
          default: ;
        endcase
      end
      if (tx_act_q) begin
        tx_cnt_q <= (tx_cnt_q == TX_LAST) ? '0 : tx_cnt_q + 16'd1;
        if (tx_cnt_q == TX_LAST) begin
          tx_sh_q  <= {1'b1, tx_sh_q[9:1]};
          tx_bit_q <= tx_bit_q + 4'd1;
        end
      end
      // First response byte is loaded on the terminating edge so its start
      // bit appears the very next cycle; later bytes follow back-to-back.
      if (term) begin
        tx_sh_q  <= {1'b1, resp_full[39:32], 1'b0};
        resp_q   <= resp_full[31:0];
        left_q   <= we_q ? 3'd0 : 3'd4;
        tx_act_q <= 1'b1;
        tx_cnt_q <= '0;
        tx_bit_q <= '0;
      end else if (tx_done) begin
        if (left_q != 3'd0) begin
          tx_sh_q  <= {1'b1, resp_q[31:24], 1'b0};
          resp_q   <= {resp_q[23:0], 8'h0};
          left_q   <= left_q - 3'd1;
          tx_cnt_q <= '0;
          tx_bit_q <= '0;
        end else begin
          tx_act_q <= 1'b0;
        end
      end
    end
  end

  assign uart_tx = tx_sh_q[0];

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Scoreboard bench for uart_wb_bridge: a UART decoder and a bus monitor pop
// expectations pushed by a command-level reference model.
module tb_uart_wb_bridge;
  localparam int CPB = 8;
  localparam int TMO = 16;
  localparam int M_ACK = 0, M_ERR = 1, M_NONE = 2;

  logic sys_clk = 1'b0;
  logic sys_rst;
  logic uart_rx;
  logic uart_tx;
  logic busy;

  uart_wb_bridge_if #(.ADDR_WIDTH(32)) wb ();

  uart_wb_bridge #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx),
    .busy    (busy),
    .wb      (wb)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] mosi;
    bit          chk_mosi;
    int          dur;
  } bus_exp_t;

  logic [7:0] exp_q[$];
  bus_exp_t   bus_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  int          sl_mode  = M_ACK;
  int          sl_delay = 0;
  logic [31:0] sl_data  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the bus should see and what bytes come back.
  task automatic expect_cmd(input bit w, input logic [31:0] a, input logic [31:0] d,
                            input int mode, input int dly, input logic [31:0] rd);
    bus_exp_t e;
    logic [31:0] rv;
    logic [7:0]  st;
    e.adr = a; e.we = w; e.mosi = d; e.chk_mosi = w;
    e.dur = (mode == M_NONE) ? TMO : dly + 1;
    bus_q.push_back(e);
    st = (mode == M_ERR) ? 8'h01 : (mode == M_NONE) ? 8'h02 : 8'h00;
    if (!w) begin
      rv = (mode == M_ACK) ? rd : 32'h0;
      for (int i = 3; i >= 0; i--) exp_q.push_back(rv[8*i +: 8]);
    end
    exp_q.push_back(st);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    uart_rx = 1'b0;
    repeat (CPB) @(posedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(posedge sys_clk);
    end
    uart_rx = good_stop;
    repeat (CPB) @(posedge sys_clk);
    uart_rx = 1'b1;
    if (!good_stop) repeat (2 * CPB) @(posedge sys_clk);
  endtask

  task automatic send_cmd(input bit w, input logic [31:0] a, input logic [31:0] d);
    send_byte(w ? 8'h57 : 8'h52, 1'b1);
    send_byte(a[31:24], 1'b1);
    chk("busy_high", busy, 1);
    for (int i = 2; i >= 0; i--) send_byte(a[8*i +: 8], 1'b1);
    if (w) for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8], 1'b1);
  endtask

  task automatic run_cmd(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input int mode, input int dly, input logic [31:0] rd);
    int n;
    sl_mode = mode; sl_delay = dly; sl_data = rd;
    expect_cmd(w, a, d, mode, dly, rd);
    send_cmd(w, a, d);
    n = 0;
    while (busy && n < 4000) begin
      @(negedge sys_clk);
      n++;
    end
    chk("busy_fall", busy, 0);
    repeat (4) @(negedge sys_clk);
    chk("resp_drained", exp_q.size(), 0);
    chk("bus_drained", bus_q.size(), 0);
  endtask

  // UART decoder on the response line
  initial begin
    logic [7:0] b;
    logic [7:0] e;
    forever begin
      @(negedge sys_clk);
      if (uart_tx === 1'b0 && !sys_rst) begin
        repeat (CPB / 2) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge sys_clk);
          b[i] = uart_tx;
        end
        repeat (CPB) @(negedge sys_clk);
        chk("tx_stop_bit", uart_tx, 1);
        if (exp_q.size() == 0) begin
          chk("tx_unexpected_byte", b, 9'h100);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", b, e);
        end
      end
    end
  end

  // Bus monitor: checks request fields, stability and cycle length
  initial begin
    bus_exp_t cur;
    bit seen = 0;
    int dur = 0;
    forever begin
      @(negedge sys_clk);
      if (wb.cyc && !seen) begin
        seen = 1; dur = 1;
        if (bus_q.size() == 0) begin
          chk("bus_unexpected_cycle", wb.cyc, 0);
          cur.adr = wb.adr; cur.we = wb.we; cur.mosi = '0; cur.chk_mosi = 0; cur.dur = 0;
        end else begin
          cur = bus_q.pop_front();
        end
        chk("bus_stb", wb.stb, 1);
        chk("bus_sel", wb.sel, 4'hF);
        chk("bus_we", wb.we, cur.we);
        chk("bus_tag", wb.tag, 0);
        if (cur.chk_mosi) chk("bus_mosi", wb.mosi, cur.mosi);
        chk("bus_adr", wb.adr, cur.adr);
      end else if (wb.cyc) begin
        dur++;
        chk("bus_adr_stable", wb.adr, cur.adr);
      end else if (seen) begin
        seen = 0;
        if (cur.dur > 0) chk("bus_cycle_len", dur, cur.dur);
      end
    end
  end

  // Wishbone slave model
  initial begin
    wb.ack = 1'b0; wb.err = 1'b0; wb.miso = '0;
    forever begin
      @(negedge sys_clk);
      if (wb.cyc && wb.stb) begin
        if (sl_mode == M_NONE) begin
          for (int n = 0; n < 2000 && wb.cyc; n++) @(negedge sys_clk);
        end else begin
          repeat (sl_delay) @(negedge sys_clk);
          wb.ack = 1'b1; wb.err = (sl_mode == M_ERR); wb.miso = sl_data;
          @(negedge sys_clk);
          wb.ack = 1'b0; wb.err = 1'b0; wb.miso = '0;
        end
      end
    end
  end

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_exp_t e;
    int n;
    logic [7:0] jb;
    uart_rx = 1'b1;
    sys_rst = 1'b1;
    repeat (5) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_uart_tx", uart_tx, 1);
    chk("rst_cyc", wb.cyc, 0);
    chk("rst_stb", wb.stb, 0);
    chk("rst_we", wb.we, 0);
    chk("rst_sel", wb.sel, 0);
    chk("rst_adr", wb.adr, 0);
    chk("rst_mosi", wb.mosi, 0);
    chk("rst_busy", busy, 0);
    sys_rst = 1'b0;
    repeat (3 * CPB) @(negedge sys_clk);

    run_cmd(1, 32'h00010004, 32'hDEADBEEF, M_ACK, 3, 32'h0);
    run_cmd(0, 32'h00000010, 32'h0, M_ACK, 0, 32'h12345678);
    run_cmd(0, 32'h00000020, 32'h0, M_ERR, 2, 32'hCAFEF00D);

    // bad stop bit on an opcode, then a stray non-opcode byte
    send_byte(8'h57, 1'b0);
    send_byte(8'h41, 1'b1);
    run_cmd(0, 32'h00000044, 32'h0, M_ACK, 1, 32'hA5A55A5A);

    // reset while the bus cycle is outstanding
    sl_mode = M_NONE;
    e.adr = 32'h00000080; e.we = 0; e.mosi = '0; e.chk_mosi = 0; e.dur = 0;
    bus_q.push_back(e);
    send_cmd(0, 32'h00000080, 32'h0);
    n = 0;
    while (!wb.cyc && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    chk("rst_mid_cyc_seen", wb.cyc, 1);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    chk("rst_mid_cyc", wb.cyc, 0);
    chk("rst_mid_stb", wb.stb, 0);
    chk("rst_mid_tx", uart_tx, 1);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    chk("rst_mid_busy", busy, 0);
    repeat (20 * CPB) @(negedge sys_clk);
    chk("rst_mid_no_resp", exp_q.size(), 0);
    chk("rst_mid_bus_drained", bus_q.size(), 0);

`ifdef UART_WB_BRIDGE_TIMEOUT_EN
    run_cmd(1, 32'h00002000, 32'h01020304, M_NONE, 0, 32'h0);
`endif

    for (int k = 0; k < 10; k++) begin
      bit          w;
      int          mode;
      logic [31:0] a, d, rd;
      w  = 1'($urandom_range(0, 1));
      a  = $urandom;
      d  = $urandom;
      rd = $urandom;
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
      mode = $urandom_range(0, 2);
`else
      mode = $urandom_range(0, 1);
`endif
      if ($urandom_range(0, 1) == 1) begin
        jb = 8'($urandom_range(0, 255));
        if (jb == 8'h57 || jb == 8'h52) jb = 8'h00;
        send_byte(jb, 1'b1);
      end
      run_cmd(w, a, d, mode, $urandom_range(0, 5), rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_wb_bridge.md
Name: uart_wb_bridge

Overview:
- UART-driven Wishbone bus master for debug/bring-up: receives 8N1 command frames on a UART pin, issues single 32-bit Wishbone read/write cycles, and returns data and status over UART.
- Sits beside the CPU as a second crossbar master (NM=2), so memory and peripherals can be reached with no firmware running.

Parameters:
- CLKS_PER_BIT, 260, sys_clk cycles per UART bit (30 MHz / 115200); must be >= 4.
- ADDR_WIDTH, 32, Wishbone address width.
- TIMEOUT_CYCLES, 4096, bus timeout limit; used only with UART_WB_BRIDGE_TIMEOUT_EN.

Ports:
- sys_clk  in  1  system clock; the only clock.
- sys_rst  in  1  synchronous, active-high reset.
- uart_rx  in  1  UART receive line, asynchronous, idle high.
- uart_tx  out  1  UART transmit line, idle high.
- wb_cyc  out  1  Wishbone cycle.
- wb_stb  out  1  Wishbone strobe.
- wb_we  out  1  write enable.
- wb_tag  out  TAG_WIDTH (package)  tag; always driven 0.
- wb_sel  out  4  byte select; 4'hF during a cycle.
- wb_adr  out  ADDR_WIDTH  address.
- wb_mosi  out  32  write data.
- wb_miso  in  32  read data.
- wb_ack  in  1  slave acknowledge.
- wb_err  in  1  slave error.
- busy  out  1  high from the first opcode byte until the last response stop bit.

Behaviour:
- Reset: uart_tx=1; wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_mosi=0; busy=0; parser in IDLE; RX and TX idle. Reset mid-transaction drops wb_cyc/wb_stb at that edge, aborts any TX byte and sends no response.
- RX:
  - uart_rx passes through a 2-flop synchroniser.
  - A falling edge starts a frame; the start bit is re-checked at mid-bit, and a start bit high at mid-bit is a glitch and is ignored.
  - Data is sampled LSB first at mid-bit. A byte is valid when the stop bit samples 1; a stop bit sampling 0 is a framing error and the byte is discarded.
- Command format: opcode, then ADDR[31:24] … ADDR[7:0], then for writes D[31:24] … D[7:0] (big-endian).
  - 0x57 ('W') is a write; 0x52 ('R') is a read.
- Parser states: IDLE → ADDR (4 bytes) → WDATA (4 bytes, write only) → BUS → RESP → IDLE.
  - In IDLE, non-opcode bytes are silently dropped.
  - Bytes received in BUS/RESP are discarded.
- BUS:
  - The cycle after the final command byte is accepted: wb_cyc=wb_stb=1, wb_sel=4'hF, wb_we per opcode, wb_adr/wb_mosi from assembled regs.
  - All bus outputs are held stable until wb_ack or wb_err is sampled high; wb_cyc/wb_stb deassert on the following edge.
  - Read data is latched from wb_miso on the ack edge.
  - If ack and err are both high, err wins.
- Status codes: 0x00 ack, 0x01 err, 0x02 timeout.
- RESP:
  - A read sends 4 data bytes MSB first (zeros on err/timeout), then the status byte.
  - A write sends the status byte only.
  - The first start bit begins the cycle after bus termination. Bytes are sent back-to-back, 10 bits each (start, 8 data LSB first, stop).
  - busy falls on the cycle the last stop bit completes.
- Bit timing: a 16-bit counter counts 0..CLKS_PER_BIT-1 and wraps. RX and TX counters are independent.

Optional Feature:
- UART_WB_BRIDGE_TIMEOUT_EN defined:
  - A counter runs while in BUS.
  - When it reaches TIMEOUT_CYCLES without ack/err, cyc/stb drop on the next edge and status 0x02 is sent.
  - An ack in the same cycle as the limit is treated as ack.
- Undefined: BUS waits indefinitely and 0x02 is never produced.

Decomposition:
- Package uart_wb_pkg holds:
  - opcodes OP_WRITE=8'h57, OP_READ=8'h52;
  - status codes ST_ACK/ST_ERR/ST_TIMEOUT;
  - the WB tag width constant;
  - the parser state encoding.
- Sub-module uart_rx_byte (synchroniser, bit timing, byte_valid pulse, data out). TX and the command FSM stay in the top module.

Test Plan:
- Write: send 57 00 01 00 04 DE AD BE EF; slave acks after 3 cycles → one cycle with adr=0x00010004, mosi=0xDEADBEEF, we=1, sel=F; UART returns 00; busy then low.
- Read: send 52 00 00 00 10; slave returns miso=0x12345678 with ack → UART returns 12 34 56 78 00.
- Error: read with slave asserting err and ack together → UART returns 00 00 00 00 01; wb_cyc low one cycle after err.
- Framing/noise: a bad-stop-bit byte 0x57 followed by 0x41, then a valid read command → no bus cycle for the bad byte, and the read completes normally.
- Reset mid-BUS: assert sys_rst while wb_cyc=1 with no ack → wb_cyc=0 and uart_tx=1 after that edge; no response bytes; the next command works.
- Timeout (TIMEOUT_EN defined, TIMEOUT_CYCLES=16): write with no ack → cyc drops after 16 cycles and UART returns 02.
